// File: rtl/pid_coef_loader.sv
// pid_coef_loader: streams a host-written shadow bank of PID coefficients
// (Kp, Ki, Kd, K3 per axis) into the FOC controller's PID register files.
// The PID write port uses active-low write enables. While a stream is being
// written, the block blocks the controller's sample valid.
//
// Optional feature macro: PID_LOADER_AUTOLOAD_EN
//   defined   : the shadow resets to Kp=1<<12, Ki=1<<9, Kd=0, K3=0. One full
//               load (mask 2'b11) runs automatically after reset is released.
//   undefined : the shadow resets to zero, and nothing is written until load.
//
// Ports:
//   clk, rstb                        clock, asynchronous active-high reset
//   host_wr/axis/addr/data           shadow write port (dropped while busy)
//   load, load_mask                  one-cycle load request, axis mask {q,d}
//   busy, load_done                  stream in flight / completion pulse
//   samp_valid_in, samp_valid_out    upstream sample valid, gated copy
//   ctrl_ready                       controller idle indication
//   pid_{d,q}_{wen,addr,data}        registered PID write port (wen active-low)
module pid_coef_loader #(
    parameter int unsigned D_WIDTH = 19,
    parameter int unsigned N_COEF  = 4
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               host_wr,
    input  logic               host_axis,
    input  logic [1:0]         host_addr,
    input  logic [D_WIDTH-1:0] host_data,
    input  logic               load,
    input  logic [1:0]         load_mask,
    output logic               busy,
    output logic               load_done,
    input  logic               samp_valid_in,
    output logic               samp_valid_out,
    input  logic               ctrl_ready,
    output logic               pid_d_wen,
    output logic [D_WIDTH-1:0] pid_d_addr,
    output logic [D_WIDTH-1:0] pid_d_data,
    output logic               pid_q_wen,
    output logic [D_WIDTH-1:0] pid_q_addr,
    output logic [D_WIDTH-1:0] pid_q_data
);

    localparam int unsigned IW = (N_COEF > 1) ? $clog2(N_COEF) : 1;

    typedef enum logic [1:0] {StIdle, StPend, StWrite, StDone} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [1:0]         mask_q, mask_d;
    logic [D_WIDTH-1:0] shadow_q [2][N_COEF];
    logic               autoload;
    logic               load_req;
    logic [1:0]         load_mask_eff;

`ifdef PID_LOADER_AUTOLOAD_EN
    // High only during the first cycle after reset release. It acts as a
    // synthetic load request with both axes enabled.
    logic autoload_q;
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            autoload_q <= 1'b1;
        end else begin
            autoload_q <= 1'b0;
        end
    end
    assign autoload = autoload_q;
`else
    assign autoload = 1'b0;
`endif

    assign load_req      = load | autoload;
    assign load_mask_eff = autoload ? 2'b11 : load_mask;

    assign busy           = (state_q == StPend) || (state_q == StWrite);
    assign load_done      = (state_q == StDone);
    assign samp_valid_out = samp_valid_in && ((state_q == StIdle) || (state_q == StPend));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    mask_d  = load_mask_eff;
                    state_d = StPend;
                end
            end
            StPend: begin
                // An empty mask has nothing to write, so it completes without
                // waiting for the controller.
                if (mask_q == 2'b00) begin
                    state_d = StDone;
                end else if (ctrl_ready && !samp_valid_in) begin
                    idx_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (idx_q == IW'(N_COEF - 1)) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mask_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    // Shadow bank. A write in the same cycle as an accepted load still lands,
    // because busy only rises after that edge.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int a = 0; a < 2; a++) begin
                for (int c = 0; c < int'(N_COEF); c++) begin
`ifdef PID_LOADER_AUTOLOAD_EN
                    shadow_q[a][c] <= (c == 0) ? D_WIDTH'(1 << 12) :
                                      (c == 1) ? D_WIDTH'(1 << 9) : '0;
`else
                    shadow_q[a][c] <= '0;
`endif
                end
            end
        end else if (host_wr && !busy) begin
            shadow_q[host_axis][host_addr] <= host_data;
        end
    end

    // The PID port is registered from next-state values. This puts the write
    // beat for idx in the same cycle that the FSM holds that idx in WRITE.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            pid_d_wen  <= 1'b1;
            pid_q_wen  <= 1'b1;
            pid_d_addr <= '0;
            pid_q_addr <= '0;
            pid_d_data <= '0;
            pid_q_data <= '0;
        end else if (state_d == StWrite) begin
            pid_d_wen  <= ~mask_q[0];
            pid_q_wen  <= ~mask_q[1];
            pid_d_addr <= D_WIDTH'(idx_d);
            pid_q_addr <= D_WIDTH'(idx_d);
            pid_d_data <= shadow_q[0][idx_d];
            pid_q_data <= shadow_q[1][idx_d];
        end else begin
            pid_d_wen <= 1'b1;
            pid_q_wen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pid_coef_loader.sv
// Scoreboard bench for pid_coef_loader. The stimulus pushes the write beats
// and load_done cycles it expects. A negedge monitor pops and compares each
// beat and pulse the DUT produces.
module tb_pid_coef_loader;

    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          rstb;
    logic          host_wr;
    logic          host_axis;
    logic [1:0]    host_addr;
    logic [DW-1:0] host_data;
    logic          load;
    logic [1:0]    load_mask;
    logic          busy;
    logic          load_done;
    logic          samp_valid_in;
    logic          samp_valid_out;
    logic          ctrl_ready;
    logic          pid_d_wen, pid_q_wen;
    logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;

    pid_coef_loader #(.D_WIDTH(DW), .N_COEF(4)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .host_wr        (host_wr),
        .host_axis      (host_axis),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .load           (load),
        .load_mask      (load_mask),
        .busy           (busy),
        .load_done      (load_done),
        .samp_valid_in  (samp_valid_in),
        .samp_valid_out (samp_valid_out),
        .ctrl_ready     (ctrl_ready),
        .pid_d_wen      (pid_d_wen),
        .pid_d_addr     (pid_d_addr),
        .pid_d_data     (pid_d_data),
        .pid_q_wen      (pid_q_wen),
        .pid_q_addr     (pid_q_addr),
        .pid_q_data     (pid_q_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected beat: {cycle, d_wen, q_wen, d_addr, q_addr, d_data, q_data}
    logic [109:0]  wq[$];
    int            dq[$];
    logic [DW-1:0] sh [2][4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef PID_LOADER_AUTOLOAD_EN
                sh[a][c] = (c == 0) ? 19'h1000 : (c == 1) ? 19'h200 : 19'h0;
`else
                sh[a][c] = 19'h0;
`endif
            end
        end
    endtask

    task automatic push_stream(input int first, input logic [1:0] mask, input int n,
                               input bit done);
        if (mask == 2'b00) begin
            if (done) dq.push_back(first);
        end else begin
            for (int k = 0; k < n; k++) begin
                wq.push_back({32'(first + k), ~mask[0], ~mask[1], 19'(k), 19'(k),
                              sh[0][k], sh[1][k]});
            end
            if (done) dq.push_back(first + 4);
        end
    endtask

    // Called at a negedge. The load is captured at the next edge E. Returns
    // at the negedge after E.
    task automatic start_load(input logic [1:0] mask, input int extra, input int n,
                              input bit done);
        int e;
        load      = 1'b1;
        load_mask = mask;
        e         = cyc + 1;
        push_stream(e + 1 + extra, mask, n, done);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic host_write(input logic axis, input logic [1:0] addr,
                              input logic [DW-1:0] data, input bit lands);
        host_wr   = 1'b1;
        host_axis = axis;
        host_addr = addr;
        host_data = data;
        if (lands) sh[axis][addr] = data;
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic release_reset();
        rstb = 1'b0;
`ifdef PID_LOADER_AUTOLOAD_EN
        push_stream(cyc + 2, 2'b11, 4, 1'b1);
`endif
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [109:0] act;
        if (!rstb) begin
            act = {32'(cyc), pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr,
                   pid_d_data, pid_q_data};
            if (!pid_d_wen || !pid_q_wen) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", act);
                end else begin
                    chk("write_beat", act, wq.pop_front());
                end
            end
            if (load_done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load_done actual=cycle %0d required=none", cyc);
                end else begin
                    chk("load_done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    initial begin
        rstb          = 1'b1;
        host_wr       = 1'b0;
        host_axis     = 1'b0;
        host_addr     = 2'd0;
        host_data     = '0;
        load          = 1'b0;
        load_mask     = 2'b00;
        samp_valid_in = 1'b1;
        ctrl_ready    = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_d_wen", pid_d_wen, 1);
        chk("rst_q_wen", pid_q_wen, 1);
        chk("rst_addr", {pid_d_addr, pid_q_addr}, 0);
        chk("rst_data", {pid_d_data, pid_q_data}, 0);
        chk("rst_busy_done", {busy, load_done}, 0);
        chk("rst_svo", samp_valid_out, 1);
        samp_valid_in = 1'b0;
        release_reset();
        repeat (10) @(negedge clk);

        // Basic full load with timing of busy
        host_write(1'b0, 2'd0, 19'h1000, 1'b1);
        host_write(1'b1, 2'd1, 19'h0200, 1'b1);
        start_load(2'b11, 0, 4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("busy_window", busy, (i < 5) ? 1 : 0);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Controller not ready for 10 cycles, then valid gating
        ctrl_ready = 1'b0;
        start_load(2'b11, 10, 4, 1'b1);
        samp_valid_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("pend_busy", busy, 1);
        chk("pend_svo", samp_valid_out, 1);
        repeat (5) @(negedge clk);
        ctrl_ready    = 1'b1;
        samp_valid_in = 1'b0;
        @(negedge clk);
        samp_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stream_svo_gated", samp_valid_out, 0);
            @(negedge clk);
        end
        #1 chk("svo_resumes", samp_valid_out, 1);
        samp_valid_in = 1'b0;
        repeat (3) @(negedge clk);

        // Partial masks
        host_write(1'b0, 2'd3, 19'h12345, 1'b1);
        start_load(2'b01, 0, 4, 1'b1);
        repeat (8) @(negedge clk);
        start_load(2'b00, 0, 0, 1'b1);
        repeat (4) @(negedge clk);

        // Host write and second load both dropped while busy
        start_load(2'b11, 0, 4, 1'b1);
        host_write(1'b0, 2'd2, 19'h7, 1'b0);
        load      = 1'b1;
        load_mask = 2'b11;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        // Shadow write together with load in IDLE: new value is streamed
        host_wr   = 1'b1;
        host_axis = 1'b1;
        host_addr = 2'd3;
        host_data = 19'h5A5A5;
        sh[1][3]  = 19'h5A5A5;
        start_load(2'b11, 0, 4, 1'b1);
        host_wr = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during WRITE idx=2 aborts without load_done
        start_load(2'b11, 0, 3, 1'b0);
        repeat (3) @(negedge clk);
        #1 rstb = 1'b1;
        #1;
        chk("abort_wen", {pid_d_wen, pid_q_wen}, 2'b11);
        chk("abort_addr", {pid_d_addr, pid_q_addr}, 0);
        chk("abort_data", {pid_d_data, pid_q_data}, 0);
        chk("abort_busy_done", {busy, load_done}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        repeat (12) @(negedge clk);

        chk("writes_consumed", wq.size(), 0);
        chk("dones_consumed", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
